// File: rtl/note_player_pkg.sv
// note_player_pkg: shared widths, constants and FSM encoding
// for the note player control path (song_reader -> dds).
package note_player_pkg;

  localparam int NOTE_W        = 6;
  localparam int DUR_W         = 6;
  localparam int K_W           = 22;
  localparam int REST_NOTE     = 0;
  localparam int BEATS_PER_SEC = 48;
  localparam int SAMPLE_RATE   = 48000;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

endpackage

// File: rtl/note_freq_rom.sv
// note_freq_rom: 64-entry registered phase-increment table,
// k = round(440 * 2^((n-49)/12) * 2^22 / 48000), entry 0 = rest.
module note_freq_rom
  import note_player_pkg::*;
(
  input  logic              clk,
  input  logic [NOTE_W-1:0] addr,
  output logic [K_W-1:0]    dout
);

  logic [K_W-1:0] dout_d;
  logic [K_W-1:0] dout_q;

  // Table lookup; anything not listed (note 0) is silence.
  always_comb begin
    dout_d = '0;
    case (addr)
      6'd1:  dout_d = 22'd2403;
      6'd2:  dout_d = 22'd2546;
      6'd3:  dout_d = 22'd2697;
      6'd4:  dout_d = 22'd2858;
      6'd5:  dout_d = 22'd3028;
      6'd6:  dout_d = 22'd3208;
      6'd7:  dout_d = 22'd3398;
      6'd8:  dout_d = 22'd3600;
      6'd9:  dout_d = 22'd3815;
      6'd10: dout_d = 22'd4041;
      6'd11: dout_d = 22'd4282;
      6'd12: dout_d = 22'd4536;
      6'd13: dout_d = 22'd4806;
      6'd14: dout_d = 22'd5092;
      6'd15: dout_d = 22'd5395;
      6'd16: dout_d = 22'd5715;
      6'd17: dout_d = 22'd6055;
      6'd18: dout_d = 22'd6415;
      6'd19: dout_d = 22'd6797;
      6'd20: dout_d = 22'd7201;
      6'd21: dout_d = 22'd7629;
      6'd22: dout_d = 22'd8083;
      6'd23: dout_d = 22'd8563;
      6'd24: dout_d = 22'd9072;
      6'd25: dout_d = 22'd9612;
      6'd26: dout_d = 22'd10184;
      6'd27: dout_d = 22'd10789;
      6'd28: dout_d = 22'd11431;
      6'd29: dout_d = 22'd12110;
      6'd30: dout_d = 22'd12830;
      6'd31: dout_d = 22'd13593;
      6'd32: dout_d = 22'd14402;
      6'd33: dout_d = 22'd15258;
      6'd34: dout_d = 22'd16165;
      6'd35: dout_d = 22'd17127;
      6'd36: dout_d = 22'd18145;
      6'd37: dout_d = 22'd19224;
      6'd38: dout_d = 22'd20367;
      6'd39: dout_d = 22'd21578;
      6'd40: dout_d = 22'd22861;
      6'd41: dout_d = 22'd24221;
      6'd42: dout_d = 22'd25661;
      6'd43: dout_d = 22'd27187;
      6'd44: dout_d = 22'd28803;
      6'd45: dout_d = 22'd30516;
      6'd46: dout_d = 22'd32331;
      6'd47: dout_d = 22'd34253;
      6'd48: dout_d = 22'd36290;
      6'd49: dout_d = 22'd38448;
      6'd50: dout_d = 22'd40734;
      6'd51: dout_d = 22'd43156;
      6'd52: dout_d = 22'd45722;
      6'd53: dout_d = 22'd48441;
      6'd54: dout_d = 22'd51322;
      6'd55: dout_d = 22'd54373;
      6'd56: dout_d = 22'd57607;
      6'd57: dout_d = 22'd61032;
      6'd58: dout_d = 22'd64661;
      6'd59: dout_d = 22'd68506;
      6'd60: dout_d = 22'd72580;
      6'd61: dout_d = 22'd76896;
      6'd62: dout_d = 22'd81468;
      6'd63: dout_d = 22'd86312;
      default: dout_d = '0;
    endcase
  end

  // Registered output: one cycle from address to data.
  always_ff @(posedge clk) begin
    dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: rtl/note_player_ctrl.sv
// note_player_ctrl: note -> phase increment, beat countdown, gated
// sample pulse. NOTE_ARTIC_GAP_EN silences k_out on the last beat.
module note_player_ctrl #(
  parameter int NOTE_W = note_player_pkg::NOTE_W,
  parameter int DUR_W  = note_player_pkg::DUR_W,
  parameter int K_W    = note_player_pkg::K_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              play_enable,
  input  logic              load_new_note,
  input  logic [NOTE_W-1:0] note,
  input  logic [DUR_W-1:0]  duration,
  input  logic              beat,
  input  logic              sampling_pulse_in,
  output logic [K_W-1:0]    k_out,
  output logic              dds_sampling_pulse,
  output logic              note_active,
  output logic              note_done
);

  import note_player_pkg::*;

  state_e            state_q;
  state_e            state_d;
  logic [DUR_W-1:0]  remaining_q;
  logic [DUR_W-1:0]  remaining_d;
  logic [NOTE_W-1:0] note_q;
  logic [NOTE_W-1:0] note_d;
  logic              done_q;
  logic              done_d;
  logic              beat_en;
  logic              expire;
  logic [NOTE_W-1:0] rom_addr;
  logic [K_W-1:0]    rom_k;

  // Point the ROM at the incoming note on a load so the new
  // increment is ready the next cycle; otherwise hold the note.
  assign rom_addr = load_new_note ? note : note_q;

  note_freq_rom u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .dout (rom_k)
  );

  // State, countdown and note register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      note_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      note_q      <= note_d;
      done_q      <= done_d;
    end
  end

  // Next state: count enabled beats, expire, let a load win.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    note_d      = note_q;
    done_d      = 1'b0;
    beat_en     = beat && play_enable;
    expire      = 1'b0;
    unique case (state_q)
      IDLE: begin
      end
      PLAY: begin
        expire = (remaining_q == '0) ||
                 (beat_en && remaining_q == DUR_W'(1));
        if (expire) begin
          done_d      = 1'b1;
          state_d     = IDLE;
          remaining_d = '0;
        end else if (beat_en) begin
          remaining_d = remaining_q - DUR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_new_note) begin
      state_d     = PLAY;
      remaining_d = duration;
      note_d      = note;
    end
  end

  // Phase increment: silent in IDLE, ROM value while playing.
  always_comb begin
    k_out = '0;
    if (state_q == PLAY) begin
      k_out = rom_k;
    end
`ifdef NOTE_ARTIC_GAP_EN
    if (remaining_q == DUR_W'(1) &&
        note_q != NOTE_W'(REST_NOTE)) begin
      k_out = '0;
    end
`endif
  end

  assign note_active = (state_q == PLAY);
  assign note_done   = done_q;

  assign dds_sampling_pulse =
    sampling_pulse_in && play_enable && note_active;

endmodule
